// File: rtl/buffer_resp.sv
// buffer_resp: response side of the RPC DRAM controller. Records accepted
//   transactions, buffers DRAM read words, emits in-order R bursts with last
//   and one B response per completed write.
// Latency: a read word pushed in cycle N is presented on r_* in cycle N+1.
//   The data FIFO is registered and has no fall-through path.
// Backpressure: reads are granted only when the whole burst fits in
//   unreserved FIFO space, so dram_r_valid_i never needs to stall.
//   r_ready_i / b_ready_i stall the R / B channels.
// Ports:
//   clk_i, rst_i (async, active high)
//   trx_*                       transaction handshake from the command FSM
//   dram_r_valid_i/_data_i      read words from the PHY
//   wr_done_i                   one write finished on DRAM
//   r_*                         AXI-style read data channel
//   b_*                         write response channel
//   r_free_o                    unreserved data FIFO words
//   err_o                       sticky protocol error
// Optional: define BUFFER_RESP_ERR_EN to enable err_o and the protocol
//   assertion. Otherwise err_o is tied low.
module buffer_resp #(
  parameter int unsigned DramDataWidth = 256,
  parameter int unsigned DramLenWidth  = 6,
  parameter int unsigned BufferDepth   = 4,
  parameter int unsigned RDataDepth    = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             trx_valid_i,
  output logic                             trx_ready_o,
  input  logic                             trx_is_write_i,
  input  logic [DramLenWidth-1:0]          trx_len_i,
  input  logic                             dram_r_valid_i,
  input  logic [DramDataWidth-1:0]         dram_r_data_i,
  input  logic                             wr_done_i,
  output logic [DramDataWidth-1:0]         r_data_o,
  output logic                             r_last_o,
  output logic                             r_valid_o,
  input  logic                             r_ready_i,
  output logic                             b_valid_o,
  input  logic                             b_ready_i,
  output logic [$clog2(RDataDepth+1)-1:0]  r_free_o,
  output logic                             err_o
);

  localparam int unsigned CW = $clog2(RDataDepth + 1);
  localparam int unsigned PW = (RDataDepth > 1) ? $clog2(RDataDepth) : 1;
  localparam int unsigned QW = (BufferDepth > 1) ? $clog2(BufferDepth) : 1;
  localparam int unsigned WW = $clog2(BufferDepth + 1);

  typedef enum logic {R_IDLE, R_BURST} r_state_t;

  r_state_t                  r_state;
  logic [DramLenWidth-1:0]   beat_cnt;

  logic [DramDataWidth-1:0]  data_mem [RDataDepth];
  logic [PW-1:0]             data_wr_ptr, data_rd_ptr;
  logic [CW-1:0]             fifo_cnt, reserved;

  logic [DramLenWidth-1:0]   len_mem [BufferDepth];
  logic [QW-1:0]             len_wr_ptr, len_rd_ptr;
  logic [WW-1:0]             len_cnt;

  logic [WW-1:0]             wr_out, b_cnt;

  logic [CW-1:0]             len_beats;
  logic                      rd_ok, wr_ok, acc_rd, acc_wr;
  logic                      push, r_hs, len_pop, b_hs, done_ok;

  function automatic logic [PW-1:0] data_ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RDataDepth - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [QW-1:0] len_ptr_inc(input logic [QW-1:0] p);
    return (p == QW'(BufferDepth - 1)) ? '0 : p + QW'(1);
  endfunction

  // Space accounting: words in the FIFO plus words promised to granted reads.
  assign len_beats = CW'(trx_len_i) + CW'(1);
  assign r_free_o  = CW'(RDataDepth) - fifo_cnt - reserved;

  assign rd_ok       = (len_cnt != WW'(BufferDepth)) && (len_beats <= r_free_o);
  assign wr_ok       = wr_out < WW'(BufferDepth);
  assign trx_ready_o = trx_is_write_i ? wr_ok : rd_ok;
  assign acc_rd      = trx_valid_i && !trx_is_write_i && rd_ok;
  assign acc_wr      = trx_valid_i && trx_is_write_i && wr_ok;

  // Unreserved read data is dropped; reserved!=0 already implies room, the
  // full check only guards against a broken reservation count.
  assign push = dram_r_valid_i && (reserved != '0) && (fifo_cnt != CW'(RDataDepth));

  assign r_valid_o = (r_state == R_BURST) && (fifo_cnt != '0);
  assign r_last_o  = r_valid_o && (beat_cnt == len_mem[len_rd_ptr]);
  assign r_data_o  = r_valid_o ? data_mem[data_rd_ptr] : '0;
  assign r_hs      = r_valid_o && r_ready_i;
  assign len_pop   = r_hs && r_last_o;

  // A completion is only meaningful while some accepted write lacks one.
  assign done_ok   = wr_done_i && (b_cnt != wr_out);
  assign b_valid_o = b_cnt != '0;
  assign b_hs      = b_valid_o && b_ready_i;

  // Storage arrays carry no reset; the pointers and counts define validity.
  always_ff @(posedge clk_i) begin
    if (push)   data_mem[data_wr_ptr] <= dram_r_data_i;
    if (acc_rd) len_mem[len_wr_ptr]   <= trx_len_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_wr_ptr <= '0;
      data_rd_ptr <= '0;
      fifo_cnt    <= '0;
      reserved    <= '0;
      len_wr_ptr  <= '0;
      len_rd_ptr  <= '0;
      len_cnt     <= '0;
      wr_out      <= '0;
      b_cnt       <= '0;
    end else begin
      if (push)    data_wr_ptr <= data_ptr_inc(data_wr_ptr);
      if (r_hs)    data_rd_ptr <= data_ptr_inc(data_rd_ptr);
      if (acc_rd)  len_wr_ptr  <= len_ptr_inc(len_wr_ptr);
      if (len_pop) len_rd_ptr  <= len_ptr_inc(len_rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(r_hs);
      reserved <= reserved + (acc_rd ? len_beats : '0) - CW'(push);
      len_cnt  <= len_cnt + WW'(acc_rd) - WW'(len_pop);
      wr_out   <= wr_out + WW'(acc_wr) - WW'(b_hs);
      b_cnt    <= b_cnt + WW'(done_ok) - WW'(b_hs);
    end
  end

  // R burst sequencer. On the final beat the next burst starts immediately
  // if its length was already queued before this cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= R_IDLE;
      beat_cnt <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          beat_cnt <= '0;
          if (len_cnt != '0) r_state <= R_BURST;
        end
        R_BURST: begin
          if (r_hs) begin
            if (r_last_o) begin
              beat_cnt <= '0;
              r_state  <= (len_cnt > WW'(1)) ? R_BURST : R_IDLE;
            end else begin
              beat_cnt <= beat_cnt + DramLenWidth'(1);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef BUFFER_RESP_ERR_EN
  logic err_q;
  logic err_event;

  assign err_event = (dram_r_valid_i && !push) || (wr_done_i && !done_ok);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          err_q <= 1'b0;
    else if (err_event) err_q <= 1'b1;
  end

  assign err_o = err_q;

  a_no_protocol_error: assert property (@(posedge clk_i) disable iff (rst_i) !err_event);
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_resp.sv
module tb_buffer_resp;

`ifdef BUFFER_RESP_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         trx_valid = 1'b0;
  logic         trx_ready;
  logic         trx_is_write = 1'b0;
  logic [5:0]   trx_len = '0;
  logic         dram_valid = 1'b0;
  logic [255:0] dram_data = '0;
  logic         wr_done = 1'b0;
  logic [255:0] r_data;
  logic         r_last;
  logic         r_valid;
  logic         r_ready = 1'b0;
  logic         b_valid;
  logic         b_ready = 1'b0;
  logic [6:0]   r_free;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;

  buffer_resp dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .trx_valid_i    (trx_valid),
    .trx_ready_o    (trx_ready),
    .trx_is_write_i (trx_is_write),
    .trx_len_i      (trx_len),
    .dram_r_valid_i (dram_valid),
    .dram_r_data_i  (dram_data),
    .wr_done_i      (wr_done),
    .r_data_o       (r_data),
    .r_last_o       (r_last),
    .r_valid_o      (r_valid),
    .r_ready_i      (r_ready),
    .b_valid_o      (b_valid),
    .b_ready_i      (b_ready),
    .r_free_o       (r_free),
    .err_o          (err)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [255:0] m_data[$];   // words waiting to be returned
  int           m_lens[$];   // granted read lengths, oldest first
  int           m_res = 0;   // words promised but not yet delivered
  int           m_beat = 0;  // beats already returned from the head burst
  bit           m_burst = 0; // sequencer has picked up the head burst
  int           m_wr_out = 0;
  int           m_b = 0;
  bit           m_err = 0;

  typedef struct {
    logic         ready;
    logic         rv;
    logic         last;
    logic         bv;
    logic [255:0] data;
    int           free;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    e.free  = 64 - m_data.size() - m_res;
    e.ready = trx_is_write ? (m_wr_out < 4)
                           : (m_lens.size() < 4 && (int'(trx_len) + 1) <= e.free);
    e.rv    = m_burst && m_data.size() > 0;
    e.last  = e.rv && (m_beat == m_lens[0]);
    e.data  = e.rv ? m_data[0] : '0;
    e.bv    = m_b != 0;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data.delete();
      m_lens.delete();
      m_res = 0; m_beat = 0; m_burst = 0; m_wr_out = 0; m_b = 0; m_err = 0;
    end else begin
      exp_t e;
      bit acc, rhs, bhs, pushed, spur;
      e      = model_out();
      acc    = trx_valid && e.ready;
      rhs    = e.rv && r_ready;
      bhs    = e.bv && b_ready;
      pushed = dram_valid && m_res > 0 && m_data.size() < 64;
      spur   = wr_done && (m_b == m_wr_out);
      if (ErrEn && ((dram_valid && !pushed) || spur)) m_err = 1;
      if (rhs) begin
        void'(m_data.pop_front());
        if (e.last) begin
          void'(m_lens.pop_front());
          m_beat  = 0;
          m_burst = m_lens.size() > 0;
        end else begin
          m_beat++;
        end
      end else if (!m_burst && m_lens.size() > 0) begin
        m_burst = 1;
        m_beat  = 0;
      end
      if (pushed) begin
        m_data.push_back(dram_data);
        m_res--;
      end
      if (acc && !trx_is_write) begin
        m_lens.push_back(int'(trx_len));
        m_res += int'(trx_len) + 1;
      end
      if (acc && trx_is_write) m_wr_out++;
      if (bhs) begin m_wr_out--; m_b--; end
      if (wr_done && !spur) m_b++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = model_out();
    check("cmp_trx_ready", trx_ready, e.ready);
    check("cmp_r_valid",   r_valid,   e.rv);
    check("cmp_r_last",    r_last,    e.last);
    check("cmp_r_data",    r_data,    e.data);
    check("cmp_b_valid",   b_valid,   e.bv);
    check("cmp_r_free",    r_free,    e.free);
    check("cmp_err",       err,       m_err);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  int k;
  int first_c;
  int acc_c;
  int cyc63;
  int cyc64;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_free",  r_free,  64);
    check("rst_ready",   trx_ready, 1);
    check("rst_b_valid", b_valid, 0);
    check("rst_r_data",  r_data,  0);
    check("rst_err",     err,     0);
    @(posedge clk); #1 rst = 1'b0;

    // Single len=3 read, four words back to back.
    trx_valid = 1; trx_is_write = 0; trx_len = 3; r_ready = 1;
    @(negedge clk) check("t1_accept_rdy", trx_ready, 1);
    @(posedge clk); #1 trx_valid = 0;
    @(negedge clk) check("t1_free_reserved", r_free, 60);
    @(posedge clk); #1;
    k = 0; first_c = -1;
    for (int c = 0; c < 10; c++) begin
      dram_valid = (c < 4);
      dram_data  = 256'hA0 + 256'(c);
      @(negedge clk);
      if (r_valid && r_ready) begin
        if (first_c < 0) first_c = c;
        check("t1_beat_data", r_data, 256'hA0 + 256'(k));
        check("t1_beat_last", r_last, k == 3);
        k++;
      end
      @(posedge clk); #1;
    end
    dram_valid = 0;
    check("t1_beat_count", k, 4);
    check("t1_first_beat_cycle", first_c, 1);
    @(negedge clk) check("t1_free_drained", r_free, 64);
    @(posedge clk); #1;

    // len=63 fills the buffer; len=0 waits, then follows with no bubble.
    trx_valid = 1; trx_len = 63;
    @(negedge clk) check("t2_big_rdy", trx_ready, 1);
    @(posedge clk); #1 trx_len = 0;
    @(negedge clk);
    check("t2_small_held", trx_ready, 0);
    check("t2_free_zero", r_free, 0);
    @(posedge clk); #1;
    k = 0; acc_c = -1; cyc63 = -1; cyc64 = -1;
    for (int c = 0; c < 70; c++) begin
      bit accepted;
      accepted   = 0;
      dram_valid = (c < 65);
      dram_data  = 256'h1000 + 256'(c);
      @(negedge clk);
      if (trx_valid && trx_ready) begin accepted = 1; acc_c = c; end
      if (r_valid && r_ready) begin
        check("t2_beat_data", r_data, 256'h1000 + 256'(k));
        check("t2_beat_last", r_last, (k == 63) || (k == 64));
        if (k == 63) cyc63 = c;
        if (k == 64) cyc64 = c;
        k++;
      end
      @(posedge clk); #1;
      if (accepted) trx_valid = 0;
    end
    dram_valid = 0;
    check("t2_beat_count", k, 65);
    check("t2_small_accept_cycle", acc_c, 2);
    check("t2_no_bubble", cyc64 - cyc63, 1);

    // R back-pressure mid-burst.
    trx_valid = 1; trx_len = 7;
    @(posedge clk); #1 trx_valid = 0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      dram_valid = (c < 8);
      dram_data  = 256'h2000 + 256'(c);
      r_ready    = !(c >= 3 && c < 8);
      @(negedge clk);
      if (c == 3 || c == 7) begin
        check("t3_stall_data", r_data, 256'h2002);
        check("t3_stall_last", r_last, 0);
        check("t3_stall_free", r_free, 58);
      end
      if (r_valid && r_ready) begin
        check("t3_beat_data", r_data, 256'h2000 + 256'(k));
        check("t3_beat_last", r_last, k == 7);
        k++;
      end
      @(posedge clk); #1;
    end
    dram_valid = 0; r_ready = 1;
    check("t3_beat_count", k, 8);

    // Writes: four outstanding max, coincident done + B handshake.
    trx_valid = 1; trx_is_write = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) check("t4_wr_rdy", trx_ready, 1);
      @(posedge clk); #1;
    end
    @(negedge clk) check("t4_wr_full", trx_ready, 0);
    @(posedge clk); #1 trx_valid = 0; trx_is_write = 0; wr_done = 1;
    @(posedge clk); #1;
    @(posedge clk); #1 wr_done = 0;
    @(negedge clk) check("t4_b_valid_two", b_valid, 1);
    @(posedge clk); #1 b_ready = 1; wr_done = 1;
    @(negedge clk) check("t4_b_valid_coinc", b_valid, 1);
    @(posedge clk); #1 wr_done = 0;
    @(negedge clk) check("t4_b_after_coinc", b_valid, 1);
    @(posedge clk); #1;
    @(negedge clk) check("t4_b_last_one", b_valid, 1);
    @(posedge clk); #1;
    @(negedge clk) check("t4_b_empty", b_valid, 0);
    @(posedge clk); #1 wr_done = 1;
    @(posedge clk); #1 wr_done = 0;
    @(negedge clk) check("t4_b_fourth", b_valid, 1);
    @(posedge clk); #1 wr_done = 1;
    @(posedge clk); #1 wr_done = 0;
    @(negedge clk) check("t4_spurious_done", b_valid, 0);
    @(posedge clk); #1 b_ready = 0;

    // Reset in the middle of a buffered burst with a pending B.
    trx_valid = 1; trx_is_write = 1;
    @(posedge clk); #1 trx_is_write = 0; trx_len = 15; wr_done = 1; r_ready = 0;
    @(posedge clk); #1 trx_valid = 0; wr_done = 0;
    for (int c = 0; c < 10; c++) begin
      dram_valid = 1;
      dram_data  = 256'h3000 + 256'(c);
      @(posedge clk); #1;
    end
    dram_valid = 0;
    @(negedge clk);
    check("t5_pre_r_valid", r_valid, 1);
    check("t5_pre_b_valid", b_valid, 1);
    check("t5_pre_free", r_free, 48);
    @(posedge clk); #1;
    #1 rst = 1'b1;
    #1;
    check("t5_rst_r_valid", r_valid, 0);
    check("t5_rst_b_valid", b_valid, 0);
    check("t5_rst_free", r_free, 64);
    check("t5_rst_data", r_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    trx_valid = 1; trx_len = 0; r_ready = 1;
    @(posedge clk); #1 trx_valid = 0; dram_valid = 1; dram_data = 256'h4000;
    @(posedge clk); #1 dram_valid = 0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (r_valid && r_ready) begin
        check("t5_new_data", r_data, 256'h4000);
        check("t5_new_last", r_last, 1);
        k++;
      end
      @(posedge clk); #1;
    end
    check("t5_new_count", k, 1);

    // Read data with nothing outstanding is dropped.
    dram_valid = 1; dram_data = 256'h5555;
    @(posedge clk); #1 dram_valid = 0;
    @(negedge clk);
    check("t6_err_set", err, ErrEn);
    check("t6_dropped", r_valid, 0);
    check("t6_free", r_free, 64);
    repeat (3) @(posedge clk);
    @(negedge clk) check("t6_err_held", err, ErrEn);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
